top_memoryaccess: RTL and testbench

//  Memory-access stage of the multicycle RV32I core. It sits between top_execute and the writeback stage.
//  It consumes the *_em outputs of execute and performs LB/LH/LW/LBU/LHU/SB/SH/SW on a req/ack data-memory bus.
//  It holds the state machine in the memory-access phase until the bus completes.
//  It registers the *_mw results (rd data, rd select, next PC, jump state, decoded op) for writeback.

---
 rtl/top_memoryaccess_pkg.sv | 23 ++
 rtl/top_memoryaccess_if.sv | 16 +
 rtl/mem_lane_align.sv | 55 +++++
 rtl/top_memoryaccess.sv | 150 +++++++++++++++
 tb/tb_top_memoryaccess.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/top_memoryaccess_pkg.sv
// Shared widths, decoded-op bit positions, funct3 codes and FSM encodings for the memory-access stage.
package top_memoryaccess_pkg;

    localparam int XLEN          = 32;
    localparam int OPLEN         = 9;

    localparam int FUNCT3_BIT_L  = 0;
    localparam int FUNCT3_BIT_M  = 2;
    localparam int USE_LOAD_BIT  = 3;
    localparam int USE_STORE_BIT = 4;
    localparam int USE_RD_BIT    = 5;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

endpackage

// File: rtl/top_memoryaccess_if.sv
// Data-memory req/ack bus: the stage drives a registered request, the memory answers with a 1-cycle ack.
interface top_memoryaccess_if;
    import top_memoryaccess_pkg::*;

    logic            req;
    logic            we;
    logic [XLEN-1:0] addr;
    logic [3:0]      be;
    logic [XLEN-1:0] wdata;
    logic [XLEN-1:0] rdata;
    logic            ack;

    modport master (output req, we, addr, be, wdata, input rdata, ack);
    modport slave  (input req, we, addr, be, wdata, output rdata, ack);

endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store enables/replicated data, load lane extraction and extension, alignment check.
// Purely combinational; no latency, no backpressure.
module mem_lane_align
    import top_memoryaccess_pkg::*;
(
    input  logic [1:0]      off,
    input  logic [2:0]      f3,
    input  logic            is_store,
    input  logic [XLEN-1:0] rs2,
    input  logic [XLEN-1:0] rdata,
    output logic [3:0]      be,
    output logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] load_ext,
    output logic            misaligned
);

    logic [XLEN-1:0] lane;

    always_comb begin
        lane       = rdata >> {off, 3'b000};
        misaligned = ((f3[1:0] == 2'b01) && (off == 2'd3)) ||
                     ((f3[1:0] == 2'b10) && (off != 2'd0));

        be    = 4'b1111;
        wdata = rs2;
        if (is_store) begin
            case (f3[1:0])
                2'b00: begin
                    be    = 4'b0001 << off;
                    wdata = {4{rs2[7:0]}};
                end
                2'b01: begin
                    be    = 4'b0011 << off;
                    wdata = {2{rs2[15:0]}};
                end
                2'b10: begin
                    be    = 4'b1111;
                    wdata = rs2;
                end
                default: be = 4'b0000;
            endcase
        end

        // Extension runs on the shifted lane so X in rdata flows straight through.
        case (f3)
            F3_LB:   load_ext = {{(XLEN-8){lane[7]}}, lane[7:0]};
            F3_LH:   load_ext = {{(XLEN-16){lane[15]}}, lane[15:0]};
            F3_LW:   load_ext = lane;
            F3_LBU:  load_ext = {{(XLEN-8){1'b0}}, lane[7:0]};
            F3_LHU:  load_ext = {{(XLEN-16){1'b0}}, lane[15:0]};
            default: load_ext = '0;
        endcase
    end

endmodule

// File: rtl/top_memoryaccess.sv
// RV32I memory-access stage: runs loads/stores on the req/ack bus and registers results for writeback.
// Latency 1 clk for non-memory ops, ack+2 for memory ops; stalls the phase machine until the bus completes.
module top_memoryaccess
    import top_memoryaccess_pkg::*;
#(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               phase_memoryaccess,
    input  logic [OPLEN-1:0]   decoded_op_em,
    input  logic               jump_state_em,
    input  logic [4:0]         rdsel_em,
    input  logic [XLEN-1:0]    next_pc_em,
    input  logic [XLEN-1:0]    alu_out_em,
    input  logic [XLEN-1:0]    rs2data_em,
    top_memoryaccess_if.master dmem,
    output logic               stall_memoryaccess,
    output logic [OPLEN-1:0]   decoded_op_mw,
    output logic               jump_state_mw,
    output logic [4:0]         rdsel_mw,
    output logic [XLEN-1:0]    next_pc_mw,
    output logic [XLEN-1:0]    rd_data_mw,
    output logic               mem_err
);

    localparam int              CW       = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(ACK_TIMEOUT - 1);

    logic [1:0]       state;
    logic [CW-1:0]    ack_cnt;
    logic [XLEN-1:0]  rd_cap;
    logic             timed_out;

    logic [2:0]       f3;
    logic             is_load;
    logic             is_store;
    logic             memop;
    logic             misaligned;
    logic             launch;
    logic             capture;
    logic [3:0]       lane_be;
    logic [XLEN-1:0]  lane_wdata;
    logic [XLEN-1:0]  load_ext;
    logic [OPLEN-1:0] dop_next;
    logic [XLEN-1:0]  rd_next;
    logic             err_next;

    assign f3       = decoded_op_em[FUNCT3_BIT_M:FUNCT3_BIT_L];
    assign is_load  = decoded_op_em[USE_LOAD_BIT];
    assign is_store = decoded_op_em[USE_STORE_BIT];
    assign memop    = is_load | is_store;

    mem_lane_align u_lane (
        .off        (alu_out_em[1:0]),
        .f3         (f3),
        .is_store   (is_store),
        .rs2        (rs2data_em),
        .rdata      (dmem.rdata),
        .be         (lane_be),
        .wdata      (lane_wdata),
        .load_ext   (load_ext),
        .misaligned (misaligned)
    );

    assign stall_memoryaccess = phase_memoryaccess & memop & ~misaligned & (state != ST_DONE);
    assign launch             = phase_memoryaccess & memop & ~misaligned & (state == ST_IDLE);
    assign capture            = phase_memoryaccess & ~stall_memoryaccess;

    always_comb begin
        dop_next = decoded_op_em;
        rd_next  = alu_out_em;
        err_next = 1'b0;
        if (memop) begin
            if (misaligned) begin
                dop_next[USE_RD_BIT] = 1'b0;
                rd_next              = '0;
                err_next             = 1'b1;
            end else begin
                // Aligned memory ops only reach capture in DONE, so rd_cap is fresh here.
                if (is_store) dop_next[USE_RD_BIT] = 1'b0;
                rd_next  = rd_cap;
                err_next = timed_out;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            ack_cnt       <= '0;
            rd_cap        <= '0;
            timed_out     <= 1'b0;
            dmem.req      <= 1'b0;
            dmem.we       <= 1'b0;
            dmem.addr     <= '0;
            dmem.be       <= '0;
            dmem.wdata    <= '0;
            decoded_op_mw <= '0;
            jump_state_mw <= 1'b0;
            rdsel_mw      <= '0;
            next_pc_mw    <= '0;
            rd_data_mw    <= '0;
            mem_err       <= 1'b0;
        end else begin
            mem_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (launch) begin
                        state      <= ST_ACCESS;
                        ack_cnt    <= '0;
                        timed_out  <= 1'b0;
                        dmem.req   <= 1'b1;
                        dmem.we    <= is_store;
                        dmem.addr  <= {alu_out_em[XLEN-1:2], 2'b00};
                        dmem.be    <= lane_be;
                        dmem.wdata <= lane_wdata;
                    end
                end
                ST_ACCESS: begin
                    // Ack is checked first so a late ack on the last allowed cycle still completes.
                    if (dmem.ack) begin
                        state    <= ST_DONE;
                        dmem.req <= 1'b0;
                        rd_cap   <= is_store ? '0 : load_ext;
                    end else if (ack_cnt == CNT_LAST) begin
                        state     <= ST_DONE;
                        dmem.req  <= 1'b0;
                        rd_cap    <= '0;
                        timed_out <= 1'b1;
                    end else begin
                        ack_cnt <= ack_cnt + 1'b1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase

            if (capture) begin
                decoded_op_mw <= dop_next;
                jump_state_mw <= jump_state_em;
                rdsel_mw      <= rdsel_em;
                next_pc_mw    <= next_pc_em;
                rd_data_mw    <= rd_next;
                mem_err       <= err_next;
            end
        end
    end

endmodule

// File: tb/tb_top_memoryaccess.sv
// Directed bench for top_memoryaccess: scoreboarded ops against a reference lane/extend model.
module tb_top_memoryaccess;
    import top_memoryaccess_pkg::*;

    localparam int TO = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             phase;
    logic [OPLEN-1:0] dop_em;
    logic             js_em;
    logic [4:0]       rdsel_em;
    logic [31:0]      pc_em;
    logic [31:0]      alu_em;
    logic [31:0]      rs2_em;
    logic             stall;
    logic [OPLEN-1:0] dop_mw;
    logic             js_mw;
    logic [4:0]       rdsel_mw;
    logic [31:0]      pc_mw;
    logic [31:0]      rd_mw;
    logic             mem_err;

    top_memoryaccess_if dmem_bus ();

    top_memoryaccess #(.ACK_TIMEOUT(TO)) dut (
        .clk                (clk),
        .rst                (rst),
        .phase_memoryaccess (phase),
        .decoded_op_em      (dop_em),
        .jump_state_em      (js_em),
        .rdsel_em           (rdsel_em),
        .next_pc_em         (pc_em),
        .alu_out_em         (alu_em),
        .rs2data_em         (rs2_em),
        .dmem               (dmem_bus),
        .stall_memoryaccess (stall),
        .decoded_op_mw      (dop_mw),
        .jump_state_mw      (js_mw),
        .rdsel_mw           (rdsel_mw),
        .next_pc_mw         (pc_mw),
        .rd_data_mw         (rd_mw),
        .mem_err            (mem_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]      rd;
        logic [4:0]       rdsel;
        logic [OPLEN-1:0] dop;
        logic [31:0]      pc;
        logic             js;
        logic             err;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [OPLEN-1:0] mkop(input bit ld, input bit st, input bit rd, input logic [2:0] f3);
        logic [OPLEN-1:0] op;
        op = 9'b101_000_000;
        op[FUNCT3_BIT_M:FUNCT3_BIT_L] = f3;
        op[USE_LOAD_BIT]  = ld;
        op[USE_STORE_BIT] = st;
        op[USE_RD_BIT]    = rd;
        return op;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = d[7:0];
            2'd1:    b = d[15:8];
            2'd2:    b = d[23:16];
            default: b = d[31:24];
        endcase
        case (off)
            2'd0:    h = d[15:0];
            2'd1:    h = d[23:8];
            default: h = d[31:16];
        endcase
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b010:  return d;
            3'b100:  return {24'h0, b};
            3'b101:  return {16'h0, h};
            default: return 32'h0;
        endcase
    endfunction

    // Drives one op for the whole phase, acting as memory: ack on the ack_at-th request cycle (0 = never).
    task automatic run_op(input string name, input logic [OPLEN-1:0] op, input logic [31:0] alu,
                          input logic [31:0] rs2, input logic [31:0] rdata, input int ack_at);
        logic       ld, st, memop, mis, tmo;
        logic [2:0] f3;
        logic [1:0] off;
        logic [3:0] be_x;
        logic [31:0] wd_x;
        exp_t       e;
        exp_t       got;
        int         stall_n, req_n, exp_stall;
        bit         done;

        ld    = op[USE_LOAD_BIT];
        st    = op[USE_STORE_BIT];
        f3    = op[FUNCT3_BIT_M:FUNCT3_BIT_L];
        off   = alu[1:0];
        memop = ld | st;
        mis   = memop && (((f3[1:0] == 2'b01) && (off == 2'd3)) || ((f3[1:0] == 2'b10) && (off != 2'd0)));
        tmo   = memop && !mis && (ack_at < 1 || ack_at > TO);

        e.rdsel = 5'($urandom_range(1, 31));
        e.pc    = $urandom;
        e.js    = 1'($urandom_range(0, 1));
        e.dop   = op;
        if (mis || (memop && st)) e.dop[USE_RD_BIT] = 1'b0;
        e.err   = mis || tmo;
        if (!memop)            e.rd = alu;
        else if (mis || st || tmo) e.rd = 32'h0;
        else                   e.rd = model_load(f3, off, rdata);
        exp_stall = (!memop || mis) ? 0 : (tmo ? TO + 1 : ack_at + 1);

        be_x = 4'b1111;
        wd_x = rs2;
        if (st && f3[1:0] == 2'b00) begin
            case (off) 2'd0: be_x = 4'b0001; 2'd1: be_x = 4'b0010; 2'd2: be_x = 4'b0100; default: be_x = 4'b1000; endcase
            wd_x = {rs2[7:0], rs2[7:0], rs2[7:0], rs2[7:0]};
        end else if (st && f3[1:0] == 2'b01) begin
            be_x = off[1] ? 4'b1100 : (off[0] ? 4'b0110 : 4'b0011);
            wd_x = {rs2[15:0], rs2[15:0]};
        end

        @(negedge clk);
        dop_em   = op;
        alu_em   = alu;
        rs2_em   = rs2;
        rdsel_em = e.rdsel;
        pc_em    = e.pc;
        js_em    = e.js;
        phase    = 1'b1;
        sb.push_back(e);

        stall_n = 0;
        req_n   = 0;
        done    = 0;
        for (int c = 0; c < 64 && !done; c++) begin
            #1;
            if (dmem_bus.req) begin
                req_n++;
                check({name, "_addr"}, dmem_bus.addr, {alu[31:2], 2'b00});
                check({name, "_we"}, dmem_bus.we, st);
                check({name, "_be"}, dmem_bus.be, be_x);
                if (st) check({name, "_wdata"}, dmem_bus.wdata, wd_x);
                dmem_bus.ack   = (req_n == ack_at);
                dmem_bus.rdata = (req_n == ack_at) ? rdata : 32'h5A5A_5A5A;
            end else begin
                dmem_bus.ack = 1'b0;
            end
            if (!stall) done = 1;
            else begin
                stall_n++;
                @(negedge clk);
            end
        end
        dmem_bus.ack = 1'b0;

        check({name, "_capture_reached"}, done, 1'b1);
        check({name, "_stall_cycles"}, stall_n, exp_stall);
        check({name, "_req_cycles"}, req_n, (exp_stall == 0) ? 0 : exp_stall - 1);
        if (done) begin
            @(posedge clk);
            #1;
            got = sb.pop_front();
            check({name, "_rd_data"}, rd_mw, got.rd);
            check({name, "_rdsel"}, rdsel_mw, got.rdsel);
            check({name, "_dop"}, dop_mw, got.dop);
            check({name, "_next_pc"}, pc_mw, got.pc);
            check({name, "_jump"}, js_mw, got.js);
            check({name, "_mem_err"}, mem_err, got.err);
        end
        @(negedge clk);
        phase = 1'b0;
        @(posedge clk);
        #1;
        check({name, "_err_clear"}, mem_err, 1'b0);
        check({name, "_req_idle"}, dmem_bus.req, 1'b0);
    endtask

    initial begin
        rst            = 1'b1;
        phase          = 1'b0;
        dop_em         = '0;
        js_em          = 1'b0;
        rdsel_em       = '0;
        pc_em          = '0;
        alu_em         = '0;
        rs2_em         = '0;
        dmem_bus.ack   = 1'b0;
        dmem_bus.rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req", dmem_bus.req, 1'b0);
        check("rst_we", dmem_bus.we, 1'b0);
        check("rst_addr", dmem_bus.addr, 32'h0);
        check("rst_be", dmem_bus.be, 4'h0);
        check("rst_wdata", dmem_bus.wdata, 32'h0);
        check("rst_stall", stall, 1'b0);
        check("rst_rd_data", rd_mw, 32'h0);
        check("rst_dop", dop_mw, 9'h0);
        check("rst_rdsel", rdsel_mw, 5'h0);
        check("rst_mem_err", mem_err, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        run_op("alu",       mkop(0, 0, 1, 3'b000), 32'h1234_5678, 32'h0,         32'h0,         0);
        run_op("lb",        mkop(1, 0, 1, F3_LB),  32'h0000_0100, 32'h0,         32'h0000_80FF, 3);
        run_op("lhu",       mkop(1, 0, 1, F3_LHU), 32'h0000_0102, 32'h0,         32'h8001_0000, 2);
        run_op("lh",        mkop(1, 0, 1, F3_LH),  32'h0000_0101, 32'h0,         32'h00AB_CD00, 1);
        run_op("lbu",       mkop(1, 0, 1, F3_LBU), 32'h0000_0105, 32'h0,         32'h0000_8000, 1);
        run_op("lw",        mkop(1, 0, 1, F3_LW),  32'h0000_0200, 32'h0,         32'hDEAD_BEEF, 5);
        run_op("sb",        mkop(0, 1, 0, 3'b000), 32'h0000_0103, 32'h0000_00AB, 32'h0,         2);
        run_op("sh",        mkop(0, 1, 0, 3'b001), 32'h0000_0202, 32'h0000_1234, 32'h0,         1);
        run_op("sw",        mkop(0, 1, 0, 3'b010), 32'h0000_0300, 32'hCAFE_F00D, 32'h0,         1);
        run_op("lw_mis",    mkop(1, 0, 1, F3_LW),  32'h0000_0101, 32'h0,         32'h1111_1111, 1);
        run_op("lh_mis",    mkop(1, 0, 1, F3_LH),  32'h0000_0103, 32'h0,         32'h1111_1111, 1);
        run_op("lw_tmo",    mkop(1, 0, 1, F3_LW),  32'h0000_0300, 32'h0,         32'h7777_7777, 0);
        run_op("lw_post",   mkop(1, 0, 1, F3_LW),  32'h0000_0304, 32'h0,         32'h1122_3344, 1);
        run_op("lw_lastack",mkop(1, 0, 1, F3_LW),  32'h0000_0308, 32'h0,         32'h5566_7788, TO);
        run_op("f3_bad",    mkop(1, 0, 1, 3'b011), 32'h0000_0310, 32'h0,         32'h9999_9999, 1);

        // Reset in the middle of an access, then a stray ack.
        @(negedge clk);
        dop_em = mkop(1, 0, 1, F3_LW);
        alu_em = 32'h0000_0400;
        phase  = 1'b1;
        for (int c = 0; c < 10 && !dmem_bus.req; c++) @(negedge clk);
        check("midrst_req_seen", dmem_bus.req, 1'b1);
        @(negedge clk);
        rst   = 1'b1;
        phase = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_req_drop", dmem_bus.req, 1'b0);
        check("midrst_rd_clear", rd_mw, 32'h0);
        @(negedge clk);
        rst            = 1'b0;
        dmem_bus.ack   = 1'b1;
        dmem_bus.rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        dmem_bus.ack = 1'b0;
        @(posedge clk);
        #1;
        check("late_ack_rd", rd_mw, 32'h0);
        check("late_ack_dop", dop_mw, 9'h0);
        check("late_ack_err", mem_err, 1'b0);
        check("late_ack_req", dmem_bus.req, 1'b0);
        check("late_ack_stall", stall, 1'b0);

        check("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
